// File: rtl/home_control_core.sv
// Registered home-automation core: code authorization, heater/cooler requests, module status.
// Optional failed-attempt lockout is built when AUTH_LOCKOUT_EN is defined.
module home_control_core #(
  parameter logic [3:0] AUTH_CODE = 4'b1010,
  parameter logic [7:0] TEMP_LOW  = 8'd18,
  parameter logic [7:0] TEMP_HIGH = 8'd25,
  parameter logic [7:0] HUM_HIGH  = 8'd70
`ifdef AUTH_LOCKOUT_EN
  ,
  parameter int unsigned MAX_FAILS = 3
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] code,
  input  logic       validate,
  input  logic [7:0] temperature,
  input  logic [7:0] humidity,
  input  logic [2:0] control_signals,
  output logic       auth_status,
  output logic       auth_locked,
  output logic       heater_on,
  output logic       cooler_on,
  output logic [2:0] module_status
);

  logic       validate_q;
  logic       auth_q, auth_d;
  logic       heater_q, heater_d;
  logic       cooler_q, cooler_d;
  logic [2:0] status_q;
  logic       attempt;
  logic       code_ok;

  // A held validate counts once: only the sampled rising edge is an attempt.
  assign attempt = validate & ~validate_q;
  assign code_ok = (code == AUTH_CODE);

  // Heater wins below the low band; humidity only matters inside the band.
  always_comb begin
    heater_d = 1'b0;
    cooler_d = 1'b0;
    if (temperature < TEMP_LOW) begin
      heater_d = 1'b1;
    end else if (temperature > TEMP_HIGH) begin
      cooler_d = 1'b1;
    end else begin
      cooler_d = (humidity > HUM_HIGH);
    end
  end

`ifdef AUTH_LOCKOUT_EN
  localparam logic [3:0] MaxFails = 4'(MAX_FAILS);

  logic [3:0] fail_q, fail_d;
  logic       locked_q, locked_d;

  always_comb begin
    auth_d   = auth_q;
    fail_d   = fail_q;
    locked_d = locked_q;
    if (attempt && !locked_q) begin
      if (code_ok) begin
        auth_d = 1'b1;
        fail_d = 4'd0;
      end else begin
        auth_d = 1'b0;
        fail_d = (fail_q == 4'hf) ? fail_q : fail_q + 4'd1;
        if (fail_d >= MaxFails) begin
          locked_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fail_q   <= 4'd0;
      locked_q <= 1'b0;
    end else begin
      fail_q   <= fail_d;
      locked_q <= locked_d;
    end
  end

  assign auth_locked = locked_q;
`else
  always_comb begin
    auth_d = auth_q;
    if (attempt) begin
      auth_d = code_ok;
    end
  end

  assign auth_locked = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      validate_q <= 1'b0;
      auth_q     <= 1'b0;
      heater_q   <= 1'b0;
      cooler_q   <= 1'b0;
      status_q   <= 3'b000;
    end else begin
      validate_q <= validate;
      auth_q     <= auth_d;
      heater_q   <= heater_d;
      cooler_q   <= cooler_d;
      status_q   <= control_signals;
    end
  end

  assign auth_status   = auth_q;
  assign heater_on     = heater_q;
  assign cooler_on     = cooler_q;
  assign module_status = status_q;

endmodule

// File: tb/tb_home_control_core.sv
// Scoreboard bench for home_control_core; lockout expectations follow AUTH_LOCKOUT_EN.
module tb_home_control_core;

`ifdef AUTH_LOCKOUT_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] code = 4'd0;
  logic       validate = 1'b0;
  logic [7:0] temperature = 8'd20;
  logic [7:0] humidity = 8'd50;
  logic [2:0] control_signals = 3'b000;
  logic       auth_status, auth_locked, heater_on, cooler_on;
  logic [2:0] module_status;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    logic       auth;
    logic       lock;
    logic       heat;
    logic       cool;
    logic [2:0] mods;
  } exp_t;

  exp_t sb[$];

  home_control_core dut (
    .clk            (clk),
    .reset          (reset),
    .code           (code),
    .validate       (validate),
    .temperature    (temperature),
    .humidity       (humidity),
    .control_signals(control_signals),
    .auth_status    (auth_status),
    .auth_locked    (auth_locked),
    .heater_on      (heater_on),
    .cooler_on      (cooler_on),
    .module_status  (module_status)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are already set; push the expectation, clock once, then pop and compare.
  task automatic step(input string tag, input logic ea, input logic el, input logic eh,
                      input logic ec, input logic [2:0] em);
    exp_t e;
    sb.push_back('{tag, ea, el, eh, ec, em});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq({e.tag, ".auth"}, 32'(auth_status), 32'(e.auth));
    check_eq({e.tag, ".lock"}, 32'(auth_locked), 32'(e.lock));
    check_eq({e.tag, ".heat"}, 32'(heater_on), 32'(e.heat));
    check_eq({e.tag, ".cool"}, 32'(cooler_on), 32'(e.cool));
    check_eq({e.tag, ".mods"}, 32'(module_status), 32'(e.mods));
    @(negedge clk);
  endtask

  task automatic pulse(input string tag, input logic [3:0] c, input logic ea, input logic el);
    code = c;
    validate = 1'b1;
    step(tag, ea, el, 1'b0, 1'b0, 3'b000);
    validate = 1'b0;
    step({tag, "_lo"}, ea, el, 1'b0, 1'b0, 3'b000);
  endtask

  logic [7:0] t_tab [12] = '{8'd20, 8'd30, 8'd15, 8'd18, 8'd25, 8'd20,
                             8'd15, 8'd26, 8'd17, 8'd20, 8'd0, 8'd255};
  logic [7:0] h_tab [12] = '{8'd50, 8'd50, 8'd50, 8'd50, 8'd50, 8'd71,
                             8'd90, 8'd0, 8'd0, 8'd70, 8'd255, 8'd0};
  logic [1:0] hc_tab [12] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b01,
                              2'b10, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01};
  logic [2:0] m_tab [3] = '{3'b101, 3'b111, 3'b000};

  initial begin
    @(negedge clk);
    step("reset", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    reset = 1'b0;

    pulse("auth_ok", 4'b1010, 1'b1, 1'b0);
    step("auth_hold", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    pulse("auth_bad", 4'b1100, 1'b0, 1'b0);
    pulse("auth_ok2", 4'b1010, 1'b1, 1'b0);

    // Held validate: switching to the right code mid-hold must not count.
    code = 4'b0000;
    validate = 1'b1;
    step("held0", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    code = 4'b1010;
    for (int i = 1; i < 5; i++) step($sformatf("held%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    validate = 1'b0;
    step("held_lo", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);

    reset = 1'b1;
    step("lk_rst", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    reset = 1'b0;
    pulse("lk_bad1", 4'b0001, 1'b0, 1'b0);
    pulse("lk_bad2", 4'b0010, 1'b0, 1'b0);
    pulse("lk_bad3", 4'b0011, 1'b0, LockEn);
    pulse("lk_good", 4'b1010, !LockEn, LockEn);
    reset = 1'b1;
    step("lk_clr", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    reset = 1'b0;
    pulse("lk_reauth", 4'b1010, 1'b1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      temperature = t_tab[i];
      humidity = h_tab[i];
      step($sformatf("clim_t%0d_h%0d", t_tab[i], h_tab[i]), 1'b1, 1'b0,
           hc_tab[i][1], hc_tab[i][0], 3'b000);
    end

    for (int i = 0; i < 20; i++) begin
      logic eh, ec;
      temperature = 8'($urandom_range(0, 40));
      humidity = 8'($urandom_range(55, 85));
      eh = (temperature <= 8'd17);
      ec = (temperature >= 8'd26) || (!eh && humidity >= 8'd71);
      step($sformatf("rnd%0d", i), 1'b1, 1'b0, eh, ec, 3'b000);
    end
    temperature = 8'd20;
    humidity = 8'd50;
    step("clim_idle", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);

    for (int i = 0; i < 3; i++) begin
      control_signals = m_tab[i];
      step($sformatf("mods%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, m_tab[i]);
    end
    control_signals = 3'b110;
    temperature = 8'd10;
    reset = 1'b1;
    step("mods_rst", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);

    // Reset wins over a simultaneous correct attempt; still-high validate counts afterwards.
    control_signals = 3'b000;
    temperature = 8'd20;
    code = 4'b1010;
    validate = 1'b1;
    step("rst_vs_attempt", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    reset = 1'b0;
    step("post_rst_attempt", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    validate = 1'b0;
    step("post_rst_hold", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
